// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants and state encoding for the nibble-serial adder.
package nibble_serial_adder_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/FourBitAdder.sv
// Existing 4-bit slice adder: {Cout, z} = A + B + Cin, purely combinational.
module FourBitAdder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] z,
  output logic       Cout
);

  assign {Cout, z} = {1'b0, A} + {1'b0, B} + {4'b0000, Cin};

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit slice per clock, LSB first, carry held
// in a register between slices; start/ready handshake in, one-cycle valid out.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             ready,
  output logic             busy,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             valid
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  generate
    if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
      $error("nibble_serial_adder: WIDTH must be a positive multiple of 4");
    end
  endgenerate

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] work_next;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [3:0]       slice_z;
  logic             slice_cout;

  FourBitAdder u_slice (
    .A    (a_reg[SLICE_W*idx +: SLICE_W]),
    .B    (b_reg[SLICE_W*idx +: SLICE_W]),
    .Cin  (carry),
    .z    (slice_z),
    .Cout (slice_cout)
  );

  // NOTE: assign a default first so every path drives work_next and no latch is inferred.
  always_comb begin
    work_next = work;
    work_next[SLICE_W*idx +: SLICE_W] = slice_z;
  end

  // NOTE: state uses non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ready <= 1'b1;
      busy  <= 1'b0;
      valid <= 1'b0;
      Sum   <= '0;
      Cout  <= 1'b0;
      idx   <= '0;
      carry <= 1'b0;
      a_reg <= '0;
      b_reg <= '0;
      work  <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= A;
            b_reg <= B;
            carry <= Cin;
            idx   <= '0;
            work  <= '0;
            ready <= 1'b0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          work  <= work_next;
          carry <= slice_cout;
          if (idx == LAST_IDX) begin
            // Result registers change only on the completing edge.
            idx   <= '0;
            Sum   <= work_next;
            Cout  <= slice_cout;
            valid <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          ready <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench: 16-bit and 4-bit instances against an arithmetic reference.
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst;

  logic        start16, cin16;
  logic [15:0] a16, b16;
  logic        ready16, busy16, cout16, valid16;
  logic [15:0] sum16;

  logic        start4, cin4;
  logic [3:0]  a4, b4;
  logic        ready4, busy4, cout4, valid4;
  logic [3:0]  sum4;

  int checks   = 0;
  int failures = 0;

  logic [15:0] held_sum16  = '0;
  logic        held_cout16 = 1'b0;
  logic [3:0]  held_sum4   = '0;
  logic        held_cout4  = 1'b0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .A(a16), .B(b16), .Cin(cin16),
    .ready(ready16), .busy(busy16), .Sum(sum16), .Cout(cout16), .valid(valid16)
  );

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .A(a4), .B(b4), .Cin(cin4),
    .ready(ready4), .busy(busy4), .Sum(sum4), .Cout(cout4), .valid(valid4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [16:0] ref16(input logic [15:0] a, input logic [15:0] b, input logic c);
    return 17'(a) + 17'(b) + 17'(c);
  endfunction

  function automatic logic [4:0] ref4(input logic [3:0] a, input logic [3:0] b, input logic c);
    return 5'(a) + 5'(b) + 5'(c);
  endfunction

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic c);
    logic [16:0] r;
    r = ref16(a, b, c);
    check("op16_ready_before", 32'(ready16), 1);
    a16 = a; b16 = b; cin16 = c; start16 = 1'b1;
    tick();
    start16 = 1'b0;
    a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
    for (int k = 0; k < 4; k++) begin
      check("op16_busy", 32'(busy16), 1);
      check("op16_no_valid", 32'(valid16), 0);
      check("op16_sum_held", 32'(sum16), 32'(held_sum16));
      tick();
    end
    check("op16_valid", 32'(valid16), 1);
    check("op16_busy_done", 32'(busy16), 0);
    check("op16_ready_done", 32'(ready16), 0);
    check("op16_sum", 32'(sum16), 32'(r[15:0]));
    check("op16_cout", 32'(cout16), 32'(r[16]));
    held_sum16 = r[15:0]; held_cout16 = r[16];
    tick();
    check("op16_valid_drop", 32'(valid16), 0);
    check("op16_ready_back", 32'(ready16), 1);
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic c);
    logic [4:0] r;
    r = ref4(a, b, c);
    check("op4_ready_before", 32'(ready4), 1);
    a4 = a; b4 = b; cin4 = c; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    a4 = 4'($urandom); b4 = 4'($urandom);
    check("op4_busy", 32'(busy4), 1);
    check("op4_sum_held", 32'(sum4), 32'(held_sum4));
    tick();
    check("op4_valid", 32'(valid4), 1);
    check("op4_sum", 32'(sum4), 32'(r[3:0]));
    check("op4_cout", 32'(cout4), 32'(r[4]));
    held_sum4 = r[3:0]; held_cout4 = r[4];
    tick();
    check("op4_valid_drop", 32'(valid4), 0);
    check("op4_ready_back", 32'(ready4), 1);
  endtask

  initial begin
    int vcount;
    rst = 1'b1;
    start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
    start4  = 1'b0; a4  = '0; b4  = '0; cin4  = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // Idle after reset with no request.
    for (int i = 0; i < 10; i++) begin
      check("rst_ready", 32'(ready16), 1);
      check("rst_busy", 32'(busy16), 0);
      check("rst_valid", 32'(valid16), 0);
      check("rst_sum", 32'(sum16), 0);
      check("rst_cout", 32'(cout16), 0);
      check("rst4_ready", 32'(ready4), 1);
      check("rst4_sum", 32'(sum4), 0);
      tick();
    end

    op16(16'h1234, 16'h4321, 1'b0);
    op16(16'hFFFF, 16'h0001, 1'b0);
    op16(16'hFFFF, 16'h0000, 1'b1);

    // Start held high through RUN/DONE with operands changed after acceptance.
    a16 = 16'hC000; b16 = 16'hB000; cin16 = 1'b0; start16 = 1'b1;
    tick();
    a16 = 16'h0001; b16 = 16'h0001;
    vcount = 0;
    for (int k = 0; k < 4; k++) begin
      check("hold_busy", 32'(busy16), 1);
      if (valid16) vcount++;
      tick();
    end
    check("hold_valid", 32'(valid16), 1);
    check("hold_sum", 32'(sum16), 32'h7000);
    check("hold_cout", 32'(cout16), 1);
    tick();
    check("hold_idle_ready", 32'(ready16), 1);
    check("hold_idle_valid", 32'(valid16), 0);
    check("hold_idle_sum", 32'(sum16), 32'h7000);
    tick();
    check("hold_second_accept", 32'(busy16), 1);
    start16 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (valid16) vcount++;
      tick();
    end
    check("hold_extra_valid", 32'(vcount), 0);
    tick();
    check("hold2_valid", 32'(valid16), 1);
    check("hold2_sum", 32'(sum16), 32'h0002);
    check("hold2_cout", 32'(cout16), 0);
    held_sum16 = 16'h0002; held_cout16 = 1'b0;
    tick();

    // Reset after two RUN cycles discards the partial result.
    a16 = 16'h00FF; b16 = 16'h0001; cin16 = 1'b0; start16 = 1'b1;
    tick();
    start16 = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("abort_ready", 32'(ready16), 1);
    check("abort_busy", 32'(busy16), 0);
    check("abort_valid", 32'(valid16), 0);
    check("abort_sum", 32'(sum16), 0);
    check("abort_cout", 32'(cout16), 0);
    tick();
    rst = 1'b0;
    held_sum16 = '0; held_cout16 = 1'b0;
    held_sum4 = '0; held_cout4 = 1'b0;
    vcount = 0;
    for (int k = 0; k < 6; k++) begin
      if (valid16) vcount++;
      tick();
    end
    check("abort_no_valid", 32'(vcount), 0);
    check("abort_sum_kept", 32'(sum16), 0);
    op16(16'h0001, 16'h0001, 1'b0);

    op4(4'hC, 4'hB, 1'b0);
    op4(4'hF, 4'h0, 1'b1);

    for (int i = 0; i < 20; i++) begin
      op16(16'($urandom), 16'($urandom), 1'($urandom));
      op4(4'($urandom), 4'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
